// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, the instruction memory, the loader and the consumer.
// The controller takes the master side; the surrounding system takes the slave side.
interface imem_fetch_ctrl_if #(
    parameter int WORD_SIZE  = 19,
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic                  halt;
    logic                  stall;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [WORD_SIZE-1:0]  ld_data;
    logic                  ld_gnt;
    logic                  rd_en_im;
    logic                  wr_en_im;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic [WORD_SIZE-1:0]  mem_rdata;
    logic [WORD_SIZE-1:0]  instr_out;
    logic                  instr_valid;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [ADDR_WIDTH-1:0] pc;
    logic [2:0]            state_o;

    modport master (
        input  start, halt, stall, branch_taken, branch_target,
        input  ld_req, ld_addr, ld_data, mem_rdata,
        output ld_gnt, rd_en_im, wr_en_im, mem_addr, mem_wdata,
        output instr_out, instr_valid, instr_pc, pc, state_o
    );

    modport slave (
        output start, halt, stall, branch_taken, branch_target,
        output ld_req, ld_addr, ld_data, mem_rdata,
        input  ld_gnt, rd_en_im, wr_en_im, mem_addr, mem_wdata,
        input  instr_out, instr_valid, instr_pc, pc, state_o
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the 1024x19 single-port instruction memory: owns the PC, tracks the
// one-cycle read latency, handles stall/branch/halt and lends the memory to the loader.
module imem_fetch_ctrl #(
    parameter int                    WORD_SIZE  = 19,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_ctrl_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] HALTED = 3'd2;
    localparam logic [2:0] LOAD   = 3'd3;

    logic [2:0]            state;
    logic [2:0]            stateNext;
    logic [ADDR_WIDTH-1:0] pcQ;
    logic [ADDR_WIDTH-1:0] instrPcQ;
    logic                  validQ;
    logic                  inFetch;
    logic                  inLoad;
    logic                  issue;

    assign inFetch = (state == FETCH);
    assign inLoad  = (state == LOAD);
    assign issue   = inFetch && !bus.stall && !bus.halt && !bus.branch_taken;

    // Loader requests beat start when the core is parked; unknown encodings fall back to IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE, HALTED: begin
                if (bus.ld_req)
                    stateNext = LOAD;
                else if (bus.start)
                    stateNext = FETCH;
            end
            FETCH: begin
                if (bus.halt)
                    stateNext = HALTED;
            end
            LOAD: begin
                if (!bus.ld_req)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pcQ      <= RESET_PC;
            instrPcQ <= '0;
            validQ   <= 1'b0;
        end else begin
            state <= stateNext;
            if (inFetch) begin
                // Stall leaves validQ/instrPcQ alone: the memory output register holds the word.
                if (bus.halt) begin
                    validQ <= 1'b0;
                end else if (bus.branch_taken) begin
                    pcQ    <= bus.branch_target;
                    validQ <= 1'b0;
                end else if (!bus.stall) begin
                    pcQ      <= pcQ + ADDR_WIDTH'(1);
                    instrPcQ <= pcQ;
                    validQ   <= 1'b1;
                end
            end else begin
                validQ <= 1'b0;
                if (inLoad && !bus.ld_req)
                    pcQ <= RESET_PC;
            end
        end
    end

    assign bus.rd_en_im    = issue;
    assign bus.wr_en_im    = inLoad && bus.ld_req;
    assign bus.ld_gnt      = inLoad;
    assign bus.mem_addr    = inLoad ? bus.ld_addr : (issue ? pcQ : '0);
    assign bus.mem_wdata   = inLoad ? bus.ld_data : '0;
    assign bus.instr_out   = inFetch ? bus.mem_rdata : '0;
    assign bus.instr_valid = inFetch && validQ;
    assign bus.instr_pc    = instrPcQ;
    assign bus.pc          = pcQ;
    assign bus.state_o     = state;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a behavioural memory plus a queue of expected (pc, word) pairs
// that is drained whenever the consumer accepts an instruction.
module tb_imem_fetch_ctrl;
   localparam int WS = 19;
   localparam int AW = 10;

   typedef struct {
      logic [AW-1:0] pc;
      logic [WS-1:0] word;
   } expT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int vecCount = 0;
   int missCount = 0;
   expT sbQ[$];

   logic [WS-1:0] memArray [0:1023];
   logic [WS-1:0] shadow [0:1023];
   logic [WS-1:0] rdataQ = '0;
   logic [WS-1:0] ldTbl [3] = '{19'h7FFFF, 19'h00001, 19'h2AAAA};

   imem_fetch_ctrl_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) intf ();

   imem_fetch_ctrl #(.WORD_SIZE(WS), .ADDR_WIDTH(AW), .RESET_PC('0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf)
   );

   always #5 clk = ~clk;

   function automatic logic [WS-1:0] pattern(input int a);
      return WS'((a * 32'h1235) ^ 32'h5A5A5);
   endfunction

   // Power-up contents of the memory and of the bench's own copy of what it should hold.
   initial begin
      for (int i = 0; i < 1024; i++) begin
         memArray[i] = pattern(i);
         shadow[i]   = pattern(i);
      end
   end

   // Single-port synchronous memory whose output register holds while not reading.
   always @(posedge clk) begin
      if (intf.wr_en_im)
         memArray[intf.mem_addr] <= intf.mem_wdata;
      else if (intf.rd_en_im)
         rdataQ <= memArray[intf.mem_addr];
   end
   assign intf.mem_rdata = rdataQ;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic hl, input logic sl, input logic br,
                                input logic [AW-1:0] tgt, input logic lr,
                                input logic [AW-1:0] la, input logic [WS-1:0] ld);
      intf.start         = st;
      intf.halt          = hl;
      intf.stall         = sl;
      intf.branch_taken  = br;
      intf.branch_target = tgt;
      intf.ld_req        = lr;
      intf.ld_addr       = la;
      intf.ld_data       = ld;
   endtask

   task automatic driveQuiet();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [AW-1:0] a);
      expT e;
      e.pc   = a;
      e.word = shadow[a];
      sbQ.push_back(e);
   endtask

   task automatic expectIssue(input int a);
      checkOutput("issueEn", 32'(intf.rd_en_im), 32'd1);
      checkOutput("issueAddr", 32'(intf.mem_addr), 32'(a));
      pushExp(AW'(a));
   endtask

   // Consumer side: every accepted word must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("rdWrExclusive", 32'(intf.rd_en_im & intf.wr_en_im), 32'd0);
         if (intf.instr_valid && !intf.stall) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpectedWordPc", 32'(intf.instr_pc), 32'hFFFF_FFFF);
            end else begin
               expT e;
               e = sbQ.pop_front();
               checkOutput("instrPc", 32'(intf.instr_pc), 32'(e.pc));
               checkOutput("instrOut", 32'(intf.instr_out), 32'(e.word));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      driveQuiet();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstState", 32'(intf.state_o), 32'd0);
      checkOutput("rstPc", 32'(intf.pc), 32'd0);
      checkOutput("rstInstrPc", 32'(intf.instr_pc), 32'd0);
      checkOutput("rstValid", 32'(intf.instr_valid), 32'd0);
      checkOutput("rstRdEn", 32'(intf.rd_en_im), 32'd0);
      checkOutput("rstWrEn", 32'(intf.wr_en_im), 32'd0);
      checkOutput("rstGnt", 32'(intf.ld_gnt), 32'd0);
      advance();
      rst = 1'b0;

      // Start pulse, then sequential fetch of 0..5.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("idleRdEn", 32'(intf.rd_en_im), 32'd0);
      advance();
      for (int a = 0; a < 6; a++) begin
         driveQuiet();
         @(negedge clk);
         if (a > 0) begin
            checkOutput("seqValid", 32'(intf.instr_valid), 32'd1);
            checkOutput("seqInstrPc", 32'(intf.instr_pc), 32'(a - 1));
         end
         expectIssue(a);
         advance();
      end

      // Three stall cycles with word 5 on the output.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0);
         @(negedge clk);
         checkOutput("stallRdEn", 32'(intf.rd_en_im), 32'd0);
         checkOutput("stallPc", 32'(intf.pc), 32'd6);
         checkOutput("stallInstrPc", 32'(intf.instr_pc), 32'd5);
         checkOutput("stallValid", 32'(intf.instr_valid), 32'd1);
         checkOutput("stallInstrOut", 32'(intf.instr_out), 32'(shadow[5]));
         advance();
      end
      for (int a = 6; a < 8; a++) begin
         driveQuiet();
         @(negedge clk);
         expectIssue(a);
         advance();
      end

      // Branch at pc=8 while word 7 is valid.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'h3F0, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("brPcBefore", 32'(intf.pc), 32'd8);
      checkOutput("brRdEn", 32'(intf.rd_en_im), 32'd0);
      advance();
      driveQuiet();
      @(negedge clk);
      checkOutput("brSquash", 32'(intf.instr_valid), 32'd0);
      checkOutput("brPcAfter", 32'(intf.pc), 32'h3F0);
      expectIssue(32'h3F0);
      advance();

      // Run up to the top of memory; loader pokes mid-way and must be ignored.
      for (int a = 32'h3F1; a <= 32'h3FF; a++) begin
         if (a == 32'h3F4)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 10'h012, 19'h11111);
         else
            driveQuiet();
         @(negedge clk);
         if (a == 32'h3F4) begin
            checkOutput("fetchLdGnt", 32'(intf.ld_gnt), 32'd0);
            checkOutput("fetchWrEn", 32'(intf.wr_en_im), 32'd0);
         end
         expectIssue(a);
         advance();
      end
      driveQuiet();
      @(negedge clk);
      expectIssue(0);
      advance();

      // Halt wins over a simultaneous branch.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 10'h100, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("haltRdEn", 32'(intf.rd_en_im), 32'd0);
      advance();
      driveQuiet();
      @(negedge clk);
      checkOutput("haltState", 32'(intf.state_o), 32'd2);
      checkOutput("haltValid", 32'(intf.instr_valid), 32'd0);
      checkOutput("haltPc", 32'(intf.pc), 32'd1);
      advance();

      // Loader session writing three words at 4..6.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 10'd4, ldTbl[0]);
      @(negedge clk);
      checkOutput("ldReqWrEn", 32'(intf.wr_en_im), 32'd0);
      advance();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, AW'(4 + k), ldTbl[k]);
         @(negedge clk);
         checkOutput("ldState", 32'(intf.state_o), 32'd3);
         checkOutput("ldGnt", 32'(intf.ld_gnt), 32'd1);
         checkOutput("ldWrEn", 32'(intf.wr_en_im), 32'd1);
         checkOutput("ldRdEn", 32'(intf.rd_en_im), 32'd0);
         checkOutput("ldAddr", 32'(intf.mem_addr), 32'(4 + k));
         checkOutput("ldWdata", 32'(intf.mem_wdata), 32'(ldTbl[k]));
         shadow[4 + k] = ldTbl[k];
         advance();
      end
      driveQuiet();
      @(negedge clk);
      checkOutput("ldEndWrEn", 32'(intf.wr_en_im), 32'd0);
      checkOutput("ldEndGnt", 32'(intf.ld_gnt), 32'd1);
      advance();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("postLdState", 32'(intf.state_o), 32'd0);
      checkOutput("postLdPc", 32'(intf.pc), 32'd0);
      advance();
      for (int a = 0; a < 8; a++) begin
         driveQuiet();
         @(negedge clk);
         expectIssue(a);
         advance();
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      advance();

      // Resume from HALTED at the held pc, then reset mid-fetch.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      checkOutput("resumeState", 32'(intf.state_o), 32'd2);
      advance();
      driveQuiet();
      @(negedge clk);
      expectIssue(8);
      advance();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("midFetchRstState", 32'(intf.state_o), 32'd0);
      checkOutput("midFetchRstRdEn", 32'(intf.rd_en_im), 32'd0);
      checkOutput("midFetchRstValid", 32'(intf.instr_valid), 32'd0);
      checkOutput("midFetchRstPc", 32'(intf.pc), 32'd0);
      checkOutput("midFetchRstInstrPc", 32'(intf.instr_pc), 32'd0);
      advance();
      rst = 1'b0;

      // Reset mid-load: the pending write to 9 must never land.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 10'd9, 19'h55555);
      advance();
      @(negedge clk);
      checkOutput("midLdWrEn", 32'(intf.wr_en_im), 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("midLdRstWrEn", 32'(intf.wr_en_im), 32'd0);
      checkOutput("midLdRstGnt", 32'(intf.ld_gnt), 32'd0);
      checkOutput("midLdRstAddr", 32'(intf.mem_addr), 32'd0);
      advance();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      advance();
      for (int a = 0; a < 10; a++) begin
         driveQuiet();
         @(negedge clk);
         expectIssue(a);
         advance();
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      advance();
      driveQuiet();
      repeat (2) advance();

      checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule
